// File: rtl/wb_pkg.sv
// Shared defaults and lane helper functions for the writeback register file.
// Helpers work on a fixed wide vector; callers zero-extend inputs and truncate results.
package wb_pkg;

  localparam int unsigned DEF_DATA_W  = 16;
  localparam int unsigned DEF_INSTR_W = 16;
  localparam int unsigned DEF_DST_LSB = 8;
  localparam int unsigned FN_W        = 64;

  function automatic logic [FN_W-1:0] dst_of(input logic [FN_W-1:0] instr,
                                             input int unsigned     lsb);
    return instr >> lsb;
  endfunction

  function automatic logic [FN_W-1:0] lane_sel(input logic [FN_W-1:0] ld,
                                               input logic [FN_W-1:0] alu,
                                               input logic            isld);
    return isld ? ld : alu;
  endfunction

  function automatic int unsigned popcount(input logic [FN_W-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < FN_W; i++) begin
      if (v[i]) n++;
    end
    return n;
  endfunction

endpackage

// File: rtl/regfile_bank.sv
// Register storage with LANES prioritised write ports; the highest-index lane wins on a clash.
// The stored contents are exported flat and double as the registered snapshot.
module regfile_bank #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned NUM_REGS = 8,
  parameter int unsigned LANES    = 2,
  parameter int unsigned REG_AW   = $clog2(NUM_REGS)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [LANES-1:0]           we,
  input  logic [LANES*REG_AW-1:0]    waddr,
  input  logic [LANES*DATA_W-1:0]    wdata,
  output logic [NUM_REGS*DATA_W-1:0] regval
);

  logic [DATA_W-1:0] mem_q [NUM_REGS];
  logic [DATA_W-1:0] mem_d [NUM_REGS];

  always_comb begin
    mem_d = mem_q;
    // Ascending lane order makes the youngest lane the last (winning) assignment.
    for (int i = 0; i < LANES; i++) begin
      if (we[i]) begin
        mem_d[waddr[i*REG_AW +: REG_AW]] = wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NUM_REGS; k++) mem_q[k] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  always_comb begin
    regval = '0;
    for (int k = 0; k < NUM_REGS; k++) regval[k*DATA_W +: DATA_W] = mem_q[k];
  end

endmodule

// File: rtl/writeback_regfile_multi.sv
// Multi-lane writeback stage: lane decode, bypassed read ports, commit counter and
// same-destination conflict flag around an on-chip register bank.
module writeback_regfile_multi
  import wb_pkg::*;
#(
  parameter int unsigned DATA_W       = DEF_DATA_W,
  parameter int unsigned NUM_REGS     = 8,
  parameter int unsigned LANES        = 2,
  parameter int unsigned INSTR_W      = DEF_INSTR_W,
  parameter int unsigned DST_LSB      = DEF_DST_LSB,
  parameter int unsigned RD_PORTS     = 4,
  parameter bit          R0_HARDWIRED = 1'b0,
  parameter int unsigned CNT_W        = 16,
  localparam int unsigned REG_AW      = $clog2(NUM_REGS)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [LANES-1:0]           wb_valid,
  input  logic [LANES-1:0]           wb_isld,
  input  logic [LANES*INSTR_W-1:0]   wb_instr,
  input  logic [LANES*DATA_W-1:0]    wb_ldresult,
  input  logic [LANES*DATA_W-1:0]    wb_aluresult,
  input  logic [RD_PORTS*REG_AW-1:0] rd_addr,
  output logic [RD_PORTS*DATA_W-1:0] rd_data,
  output logic [NUM_REGS*DATA_W-1:0] regval,
  output logic [CNT_W-1:0]           commit_cnt,
  output logic                       wr_conflict
);

  logic [LANES-1:0]        eff;
  logic [REG_AW-1:0]       dst   [LANES];
  logic [DATA_W-1:0]       wdat  [LANES];
  logic [LANES*REG_AW-1:0] waddr_flat;
  logic [LANES*DATA_W-1:0] wdata_flat;
  logic [DATA_W-1:0]       stored [NUM_REGS];

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             conflict_q, conflict_d;

  always_comb begin
    waddr_flat = '0;
    wdata_flat = '0;
    for (int i = 0; i < LANES; i++) begin
      dst[i]  = REG_AW'(dst_of(FN_W'(wb_instr[i*INSTR_W +: INSTR_W]), DST_LSB));
      wdat[i] = DATA_W'(lane_sel(FN_W'(wb_ldresult[i*DATA_W +: DATA_W]),
                                 FN_W'(wb_aluresult[i*DATA_W +: DATA_W]), wb_isld[i]));
      eff[i]  = wb_valid[i] && !(R0_HARDWIRED && (dst[i] == '0));
      waddr_flat[i*REG_AW +: REG_AW] = dst[i];
      wdata_flat[i*DATA_W +: DATA_W] = wdat[i];
    end
  end

  regfile_bank #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS),
    .LANES    (LANES),
    .REG_AW   (REG_AW)
  ) u_bank (
    .clk    (clk),
    .rst    (rst),
    .we     (eff),
    .waddr  (waddr_flat),
    .wdata  (wdata_flat),
    .regval (regval)
  );

  always_comb begin
    for (int k = 0; k < NUM_REGS; k++) stored[k] = regval[k*DATA_W +: DATA_W];
  end

  // Bypass: the youngest effective lane hitting the address overrides stored data.
  always_comb begin
    rd_data = '0;
    for (int p = 0; p < RD_PORTS; p++) begin
      rd_data[p*DATA_W +: DATA_W] = stored[rd_addr[p*REG_AW +: REG_AW]];
      for (int i = 0; i < LANES; i++) begin
        if (eff[i] && (dst[i] == rd_addr[p*REG_AW +: REG_AW])) begin
          rd_data[p*DATA_W +: DATA_W] = wdat[i];
        end
      end
      if (R0_HARDWIRED && (rd_addr[p*REG_AW +: REG_AW] == '0)) begin
        rd_data[p*DATA_W +: DATA_W] = '0;
      end
    end
  end

  always_comb begin
    conflict_d = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      for (int j = i + 1; j < LANES; j++) begin
        if (eff[i] && eff[j] && (dst[i] == dst[j])) conflict_d = 1'b1;
      end
    end
    // Discarded r0 lanes still count as commits.
    cnt_d = cnt_q + CNT_W'(popcount(FN_W'(wb_valid)));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      conflict_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      conflict_q <= conflict_d;
    end
  end

  assign commit_cnt  = cnt_q;
  assign wr_conflict = conflict_q;

endmodule

// File: tb/tb_writeback_regfile_multi.sv
// Directed bench: two instances share stimulus, one default and one with r0 hardwired
// and a 4-bit commit counter.
module tb_writeback_regfile_multi;

  logic         clk;
  logic         rst;
  logic [1:0]   wb_valid;
  logic [1:0]   wb_isld;
  logic [31:0]  wb_instr;
  logic [31:0]  wb_ldresult;
  logic [31:0]  wb_aluresult;
  logic [11:0]  rd_addr;
  logic [63:0]  rd_data, rd_data_h;
  logic [127:0] regval, regval_h;
  logic [15:0]  commit_cnt;
  logic [3:0]   commit_cnt_h;
  logic         wr_conflict, wr_conflict_h;

  int n_cmp;
  int n_err;

  writeback_regfile_multi dut (
    .clk          (clk),
    .rst          (rst),
    .wb_valid     (wb_valid),
    .wb_isld      (wb_isld),
    .wb_instr     (wb_instr),
    .wb_ldresult  (wb_ldresult),
    .wb_aluresult (wb_aluresult),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .regval       (regval),
    .commit_cnt   (commit_cnt),
    .wr_conflict  (wr_conflict)
  );

  writeback_regfile_multi #(
    .R0_HARDWIRED (1'b1),
    .CNT_W        (4)
  ) dut_h (
    .clk          (clk),
    .rst          (rst),
    .wb_valid     (wb_valid),
    .wb_isld      (wb_isld),
    .wb_instr     (wb_instr),
    .wb_ldresult  (wb_ldresult),
    .wb_aluresult (wb_aluresult),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data_h),
    .regval       (regval_h),
    .commit_cnt   (commit_cnt_h),
    .wr_conflict  (wr_conflict_h)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] reg_of(input logic [127:0] rv, input int k);
    return rv[k*16 +: 16];
  endfunction

  function automatic logic [15:0] rd_of(input logic [63:0] rd, input int p);
    return rd[p*16 +: 16];
  endfunction

  task automatic set_lane(input int i, input logic v, input logic isld,
                          input logic [15:0] instr, input logic [15:0] ld,
                          input logic [15:0] alu);
    wb_valid[i]             = v;
    wb_isld[i]              = isld;
    wb_instr[i*16 +: 16]     = instr;
    wb_ldresult[i*16 +: 16]  = ld;
    wb_aluresult[i*16 +: 16] = alu;
  endtask

  task automatic clear_lanes();
    wb_valid     = '0;
    wb_isld      = '0;
    wb_instr     = 'x;
    wb_ldresult  = 'x;
    wb_aluresult = 'x;
  endtask

  task automatic set_rd(input logic [2:0] a0, input logic [2:0] a1,
                        input logic [2:0] a2, input logic [2:0] a3);
    rd_addr = {a3, a2, a1, a0};
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst   = 1'b1;
    clear_lanes();
    set_rd(3'd0, 3'd1, 3'd2, 3'd3);
    step();
    step();
    rst = 1'b0;
    repeat (3) step();

    // Reset state
    check("rst_regval_lo", regval[15:0], 16'h0000);
    check("rst_regval_any", {15'b0, |regval}, 16'd0);
    check("rst_cnt", commit_cnt, 16'd0);
    check("rst_conflict", {15'b0, wr_conflict}, 16'd0);
    check("rst_rd_any", {15'b0, |rd_data}, 16'd0);
    check("rst_cnt_h", {12'b0, commit_cnt_h}, 16'd0);

    // Single ALU write to r3 with same-cycle bypass
    @(negedge clk);
    set_lane(0, 1'b1, 1'b0, 16'h0300, 16'hDEAD, 16'hBEEF);
    set_rd(3'd3, 3'd4, 3'd0, 3'd0);
    #1;
    check("byp_r3", rd_of(rd_data, 0), 16'hBEEF);
    check("byp_r4_stored", rd_of(rd_data, 1), 16'h0000);
    step();
    check("wr_r3", reg_of(regval, 3), 16'hBEEF);
    check("cnt_1", commit_cnt, 16'd1);
    @(negedge clk);
    clear_lanes();
    #1;
    check("stored_r3", rd_of(rd_data, 0), 16'hBEEF);

    // Two lanes to r5: younger load wins, conflict pulses for one cycle
    @(negedge clk);
    set_lane(0, 1'b1, 1'b0, 16'h0500, 16'h0000, 16'h1111);
    set_lane(1, 1'b1, 1'b1, 16'h0500, 16'h2222, 16'h9999);
    set_rd(3'd5, 3'd3, 3'd0, 3'd0);
    #1;
    check("byp_r5_young", rd_of(rd_data, 0), 16'h2222);
    step();
    check("wr_r5", reg_of(regval, 5), 16'h2222);
    check("conflict_r5", {15'b0, wr_conflict}, 16'd1);
    check("cnt_3", commit_cnt, 16'd3);
    @(negedge clk);
    clear_lanes();
    step();
    check("conflict_clear", {15'b0, wr_conflict}, 16'd0);
    check("cnt_hold", commit_cnt, 16'd3);

    // Distinct destinations both commit
    @(negedge clk);
    set_lane(0, 1'b1, 1'b0, 16'h0100, 16'h0000, 16'hAAAA);
    set_lane(1, 1'b1, 1'b0, 16'h0200, 16'h0000, 16'h5555);
    set_rd(3'd1, 3'd2, 3'd5, 3'd3);
    #1;
    check("byp_r1", rd_of(rd_data, 0), 16'hAAAA);
    check("byp_r2", rd_of(rd_data, 1), 16'h5555);
    check("stored_r5", rd_of(rd_data, 2), 16'h2222);
    step();
    check("wr_r1", reg_of(regval, 1), 16'hAAAA);
    check("wr_r2", reg_of(regval, 2), 16'h5555);
    check("no_conflict", {15'b0, wr_conflict}, 16'd0);
    check("cnt_5", commit_cnt, 16'd5);

    // Write to r0: kept when writable, discarded when hardwired
    @(negedge clk);
    clear_lanes();
    set_lane(0, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h1234);
    set_rd(3'd0, 3'd1, 3'd0, 3'd0);
    #1;
    check("byp_r0", rd_of(rd_data, 0), 16'h1234);
    check("byp_r0_h", rd_of(rd_data_h, 0), 16'h0000);
    step();
    check("wr_r0", reg_of(regval, 0), 16'h1234);
    check("wr_r0_h", reg_of(regval_h, 0), 16'h0000);
    check("cnt_6", commit_cnt, 16'd6);

    // Both lanes to r0: conflict only where r0 is writable; discards still counted
    @(negedge clk);
    set_lane(0, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0A0A);
    set_lane(1, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0B0B);
    step();
    check("wr_r0_young", reg_of(regval, 0), 16'h0B0B);
    check("conflict_r0", {15'b0, wr_conflict}, 16'd1);
    check("conflict_r0_h", {15'b0, wr_conflict_h}, 16'd0);
    check("r0_h_zero", reg_of(regval_h, 0), 16'h0000);
    check("cnt_8", commit_cnt, 16'd8);
    check("cnt_8_h", {12'b0, commit_cnt_h}, 16'd8);

    // Reset wins over a same-cycle write
    @(negedge clk);
    clear_lanes();
    set_lane(0, 1'b1, 1'b0, 16'h0400, 16'h0000, 16'h7777);
    rst = 1'b1;
    step();
    check("rst_r4", reg_of(regval, 4), 16'h0000);
    check("rst_mid_regval", {15'b0, |regval}, 16'd0);
    check("rst_mid_cnt", commit_cnt, 16'd0);
    check("rst_mid_conflict", {15'b0, wr_conflict}, 16'd0);
    @(negedge clk);
    rst = 1'b0;
    step();
    check("post_rst_r4", reg_of(regval, 4), 16'h7777);
    check("post_rst_cnt", commit_cnt, 16'd1);

    // 16 more single-lane commits: 4-bit counter wraps to 1
    for (int n = 0; n < 16; n++) begin
      @(negedge clk);
      set_lane(0, 1'b1, 1'b1, 16'h0600, 16'(n + 1), 16'hFFFF);
      step();
    end
    @(negedge clk);
    clear_lanes();
    check("wrap_cnt_h", {12'b0, commit_cnt_h}, 16'd1);
    check("cnt_17", commit_cnt, 16'd17);
    check("wr_r6_last", reg_of(regval, 6), 16'h0010);
    check("r4_kept", reg_of(regval, 4), 16'h7777);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
